lfsr_seq_checker: RTL
=====================

# lfsr_seq_checker

Downstream consumer of the 8-bit up/down LFSR counter. It samples each `count`/`overflow` update, predicts the next value from the same XNOR feedback taps, and decides whether the stream is in sequence. It reports lock status, per-sample errors and a saturating error count. It sits between the LFSR counter and the test/status logic in BIST and sequence-generator designs.

## Interface

Parameters:
- `WIDTH`, 8, LFSR width; fixed to 8 by the tap constants.
- `LOCK_CNT`, 4, consecutive matching transitions needed to declare lock (1..15).
- `UNLOCK_CNT`, 2, consecutive mismatches in LOCKED that drop back to HUNT (1..15).

Ports:
- `clk`, in, 1, clock.
- `reset`, in, 1, synchronous, active-high reset.
- `valid_in`, in, 1, a new sample is present this cycle (driven from the counter's enable, delayed one cycle).
- `up_down_in`, in, 1, direction of the step that produced `data_in` (1 = up).
- `data_in`, in, 8, sampled counter value.
- `overflow_in`, in, 1, sampled counter overflow flag.
- `locked`, out, 1, checker is in LOCKED.
- `error`, out, 1, one-cycle pulse on a checked mismatch.
- `err_count`, out, 16, saturating count of `error` pulses.
- `ovf_error`, out, 1, one-cycle pulse on an overflow-flag mismatch (only when LFSR_CHK_OVF_EN is defined).

Reset is clocked on `clk`: synchronous, active-high.

## Operation

- Prediction from reference `r`:
  - up: `{~^(r & 8'h63), r[7:1]}`
  - down: `{r[6:0], ~^(r & 8'hB1)}`
- `data_in == 8'hFF` is the XNOR lockup state and always counts as a mismatch.
- States:
  - HUNT: the first `valid_in` loads `r = data_in` and moves to SYNC with `match_cnt = 0`.
  - SYNC: on each valid, a match increments `match_cnt`. When `match_cnt` reaches `LOCK_CNT`, go to LOCKED. A mismatch reloads `r`, clears `match_cnt` and stays in SYNC. No `error` pulses are produced in HUNT or SYNC.
  - LOCKED: a match clears `miss_cnt`. A mismatch pulses `error`, increments `err_count` (saturating at 16'hFFFF) and increments `miss_cnt`. When `miss_cnt` reaches `UNLOCK_CNT`, go to HUNT and clear `miss_cnt`.
- `r` is loaded with `data_in` on every valid sample in SYNC and LOCKED, whether it matched or not. A single corrupted sample therefore yields at most 2 errors, not an endless run.
- A direction change is legal: the prediction always uses `up_down_in` of the current sample.
- Cycles where `valid_in` is low change no state, counters or `r`.

## Timing

- All outputs are registered. `error`, `ovf_error` and `locked` reflect sample N in the cycle after it is presented.
- `locked` rises one cycle after the `LOCK_CNT`-th matching sample. It falls one cycle after the `UNLOCK_CNT`-th consecutive mismatch.
- Reset values: `locked = 0`, `error = 0`, `ovf_error = 0`, `err_count = 0`, state HUNT, `r = 0`, `match_cnt = 0`, `miss_cnt = 0`.
- Reset asserted mid-stream overrides `valid_in` in the same cycle. The first sample after reset deasserts is treated as a HUNT seed.
- `err_count` at 16'hFFFF holds its value while `error` still pulses.
- Back-to-back valids every cycle are supported with no bubbles.

## Configuration

- `LFSR_CHK_OVF_EN` defined:
  - In SYNC and LOCKED, each valid sample checks `overflow_in` against the expected flag: `(up_down_in ? data_in == 8'h01 : data_in == 8'h80)`.
  - A mismatch pulses `ovf_error`. It does not affect lock state or `err_count`.
- Not defined: `ovf_error` is tied to 0, `overflow_in` is unused, and no comparison logic is built.

## Structure

- Shared package/include `lfsr_chk_pkg` holds:
  - `LFSR_W = 8`, `TAPS_UP = 8'h63`, `TAPS_DN = 8'hB1`, `LOCKUP = 8'hFF`
  - state encodings: HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2
- Sub-module `lfsr_next_calc`: combinational, inputs `r` and `up_down`, output is the predicted next value. It is reused later by the generator-side models.

## Test plan

- Reset, then feed the up sequence 00, 80, C0, … with `valid_in` every cycle: `locked` rises one cycle after the 5th sample (4 matches); `error = 0`; `err_count = 0`.
- While locked, feed down 00, 01, 02, …: no errors, since the direction change is accepted.
- While locked, corrupt one sample (send 8'h55 instead of the expected value): one `error` pulse, `err_count = 1`, then a second `error` on the next sample (`r` was reloaded from 8'h55, so the following correct sample mismatches), `err_count = 2`, and `locked` drops under the default `UNLOCK_CNT = 2`.
- While locked, send 8'hFF twice: 2 error pulses, `locked` falls, state returns to HUNT; a clean sequence relocks after `LOCK_CNT` matches.
- Gap test: insert idle cycles (`valid_in = 0`) between samples: identical results to the gap-free stream; assert `reset` mid-sequence and check all outputs are 0 on the next cycle.
- With `LFSR_CHK_OVF_EN` defined: `data_in = 8'h01`, up, `overflow_in = 0` gives `ovf_error = 1`; `data_in = 8'h80`, down, `overflow_in = 1` gives no pulse.

Source files
------------

// File: rtl/lfsr_chk_pkg.sv
// Shared constants for the 8-bit XNOR LFSR checker and generator-side models.
// Holds the width, feedback taps, lockup value and the checker state encodings.
package lfsr_chk_pkg;

  localparam int         LFSR_W  = 8;
  localparam logic [7:0] TAPS_UP = 8'h63;
  localparam logic [7:0] TAPS_DN = 8'hB1;
  localparam logic [7:0] LOCKUP  = 8'hFF;

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] SYNC    = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

endpackage

// File: rtl/lfsr_next_calc.sv
// Combinational next-value predictor for the 8-bit up/down XNOR LFSR.
// The up and down steps are exact inverses of each other.
module lfsr_next_calc
  import lfsr_chk_pkg::*;
(
  input  logic [LFSR_W-1:0] r,
  input  logic              up_down,
  output logic [LFSR_W-1:0] pred
);

  always_comb begin
    if (up_down) pred = {~^(r & TAPS_UP), r[LFSR_W-1:1]};
    else         pred = {r[LFSR_W-2:0], ~^(r & TAPS_DN)};
  end

endmodule

// File: rtl/lfsr_seq_checker.sv
// Sequence checker for the up/down XNOR LFSR counter: lock tracking, error pulses, saturating count.
// Optional overflow-flag check is built only when LFSR_CHK_OVF_EN is defined.
//
//   state  | meaning
//   HUNT   | waiting for a seed sample to load the reference
//   SYNC   | counting consecutive matches toward LOCK_CNT, no error reporting
//   LOCKED | in sequence; mismatches pulse error, UNLOCK_CNT in a row return to HUNT
module lfsr_seq_checker
  import lfsr_chk_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             up_down_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             overflow_in,
  output logic             locked,
  output logic             error,
  output logic [15:0]      err_count,
  output logic             ovf_error
);

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

  logic [1:0]        state_q, state_d;
  logic [LFSR_W-1:0] r_q, r_d;
  logic [3:0]        match_cnt_q, match_cnt_d;
  logic [3:0]        miss_cnt_q, miss_cnt_d;
  logic              error_q, error_d;
  logic              locked_q, locked_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [LFSR_W-1:0] pred;
  logic              mismatch;

  lfsr_next_calc u_next (
    .r       (r_q),
    .up_down (up_down_in),
    .pred    (pred)
  );

  // The lockup value never belongs to the sequence, even if the prediction agrees.
  assign mismatch = (data_in == LOCKUP) || (data_in != pred);

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_count_d = err_count_q;
    error_d     = 1'b0;
    if (valid_in) begin
      r_d = data_in;
      case (state_q)
        HUNT: begin
          state_d     = SYNC;
          match_cnt_d = 4'd0;
        end
        SYNC: begin
          if (mismatch) begin
            match_cnt_d = 4'd0;
          end else if (match_cnt_q + 4'd1 == LOCK_C) begin
            state_d     = LOCKED;
            match_cnt_d = 4'd0;
            miss_cnt_d  = 4'd0;
          end else begin
            match_cnt_d = match_cnt_q + 4'd1;
          end
        end
        LOCKED: begin
          if (mismatch) begin
            error_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (miss_cnt_q + 4'd1 == UNLOCK_C) begin
              state_d    = HUNT;
              miss_cnt_d = 4'd0;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
            end
          end else begin
            miss_cnt_d = 4'd0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      r_q         <= '0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      error_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      error_q     <= error_d;
      locked_q    <= locked_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign error     = error_q;
  assign err_count = err_count_q;

`ifdef LFSR_CHK_OVF_EN
  logic ovf_exp;
  logic ovf_error_q, ovf_error_d;

  assign ovf_exp     = up_down_in ? (data_in == 8'h01) : (data_in == 8'h80);
  assign ovf_error_d = valid_in && (state_q != HUNT) && (overflow_in != ovf_exp);

  always_ff @(posedge clk) begin
    if (reset) ovf_error_q <= 1'b0;
    else       ovf_error_q <= ovf_error_d;
  end

  assign ovf_error = ovf_error_q;
`else
  logic unused_ovf;
  assign unused_ovf = overflow_in;
  assign ovf_error  = 1'b0;
`endif

endmodule
